// File: rtl/mmio_port_responder.sv
// Memory-mapped port responder: output latch, synchronized edge-monitored inputs and a
// free-running cycle timer in a 16-byte window on the data-memory bus.

module mmio_port_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pinAsync,
  input  logic armed,
  input  logic w1c,
  output logic syncOut,
  output logic flag
);
  logic [SYNC_STAGES-1:0] syncPipe;
  logic                   prev;
  logic                   rise;

  assign syncOut = syncPipe[SYNC_STAGES-1];
  assign rise    = syncOut & ~prev & armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncPipe <= '0;
      prev     <= 1'b0;
      flag     <= 1'b0;
    end else begin
      syncPipe <= {syncPipe[SYNC_STAGES-2:0], pinAsync};
      prev     <= syncOut;
      // a rise in the same cycle as its clear keeps the flag set
      flag     <= rise | (flag & ~w1c);
    end
  end
endmodule

module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0400,
  parameter int          PORT_WIDTH  = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [31:0]           WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [PORT_WIDTH-1:0] PortIn,
  output logic [31:0]           ReadData,
  output logic                  Hit,
  output logic [31:0]           PortOut,
  output logic                  EventPending
);
  localparam int                ARM_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_MAX = ARM_W'(SYNC_STAGES + 1);

  localparam logic [1:0] OFF_PORT_OUT = 2'd0;
  localparam logic [1:0] OFF_PORT_IN  = 2'd1;
  localparam logic [1:0] OFF_EVENT    = 2'd2;
  localparam logic [1:0] OFF_TIMER    = 2'd3;

  logic [1:0]            offset;
  logic                  wrEn;
  logic [31:0]           portOutReg;
  logic [31:0]           timerReg;
  logic [ARM_W-1:0]      armCnt;
  logic                  armed;
  logic [PORT_WIDTH-1:0] syncVec;
  logic [PORT_WIDTH-1:0] eventVec;
  logic [PORT_WIDTH-1:0] w1cVec;

  assign Hit    = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);
  assign offset = Address[3:2];
  assign wrEn   = Hit & MemWrite;

  assign PortOut      = portOutReg;
  assign EventPending = |eventVec;
  assign w1cVec       = (wrEn && offset == OFF_EVENT) ? WriteData[PORT_WIDTH-1:0]
                                                      : '0;

  // Edge detection stays off until the synchronizer and prev stage hold post-reset data,
  // so an input already high at reset release is not reported as a rise.
  assign armed = (armCnt == ARM_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      armCnt <= '0;
    else if (!armed)
      armCnt <= armCnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      portOutReg <= '0;
    else if (wrEn && offset == OFF_PORT_OUT)
      portOutReg <= WriteData;
  end

  // A store to TIMER takes priority over that cycle's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timerReg <= '0;
    else if (wrEn && offset == OFF_TIMER)
      timerReg <= WriteData;
    else
      timerReg <= timerReg + 32'd1;
  end

  for (genvar i = 0; i < PORT_WIDTH; i++) begin : gLane
    mmio_port_lane #(
      .SYNC_STAGES(SYNC_STAGES)
    ) uLane (
      .clk     (clk),
      .reset   (reset),
      .pinAsync(PortIn[i]),
      .armed   (armed),
      .w1c     (w1cVec[i]),
      .syncOut (syncVec[i]),
      .flag    (eventVec[i])
    );
  end

  always_comb begin
    ReadData = '0;
    if (Hit && MemRead) begin
      unique case (offset)
        OFF_PORT_OUT: ReadData = portOutReg;
        OFF_PORT_IN:  ReadData[PORT_WIDTH-1:0] = syncVec;
        OFF_EVENT:    ReadData[PORT_WIDTH-1:0] = eventVec;
        OFF_TIMER:    ReadData = timerReg;
        default:      ReadData = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder: inputs change just after the falling edge,
// outputs are sampled in the low phase away from the rising edge.

module tb_mmio_port_responder;
  localparam logic [31:0] BASE = 32'h1001_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData;
  logic        MemWrite, MemRead;
  logic [7:0]  PortIn;
  logic [31:0] ReadData, PortOut;
  logic        Hit, EventPending;

  int errors = 0;
  int checks = 0;
  logic [31:0] d;

  mmio_port_responder #(.BASE_ADDR(BASE), .PORT_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
    .ReadData(ReadData), .Hit(Hit), .PortOut(PortOut), .EventPending(EventPending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    Address = addr; MemRead = 1'b1; MemWrite = 1'b0;
    #1 data = ReadData;
    MemRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    Address = addr; WriteData = data; MemWrite = 1'b1; MemRead = 1'b0;
    tick();
    MemWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
    #1;
    chk("rst_portout", PortOut, 32'h0);
    chk("rst_evpend", {31'b0, EventPending}, 32'h0);
    chk("rst_rdata", ReadData, 32'h0);
    tick(2);
    reset = 1'b0;
    rd(BASE + 32'hC, d); chk("timer_start", d, 32'h0);
    tick();
    rd(BASE + 32'hC, d); chk("timer_inc", d, 32'h1);

    // T1 output latch
    wr(BASE, 32'hDEADBEEF);
    chk("t1_portout", PortOut, 32'hDEADBEEF);
    Address = BASE; MemRead = 1'b1; #1;
    chk("t1_hit", {31'b0, Hit}, 32'h1);
    chk("t1_read", ReadData, 32'hDEADBEEF);
    MemRead = 1'b0; #1;
    chk("t1_noread", ReadData, 32'h0);
    Address = BASE; WriteData = 32'h1234_5678; MemWrite = 1'b1; MemRead = 1'b1; #1;
    chk("rw_prewrite", ReadData, 32'hDEADBEEF);
    tick();
    MemWrite = 1'b0; MemRead = 1'b0;
    chk("rw_written", PortOut, 32'h1234_5678);
    wr(BASE, 32'hDEADBEEF);

    // T2 synchronizer and edge flags
    tick(3);
    PortIn = 8'hA5;
    tick();
    rd(BASE + 32'h4, d); chk("t2_in_1edge", d, 32'h0);
    tick();
    rd(BASE + 32'h4, d); chk("t2_in_2edge", d, 32'hA5);
    rd(BASE + 32'h8, d); chk("t2_ev_2edge", d, 32'h0);
    chk("t2_pend_2edge", {31'b0, EventPending}, 32'h0);
    tick();
    rd(BASE + 32'h8, d); chk("t2_ev_3edge", d, 32'hA5);
    chk("t2_pend", {31'b0, EventPending}, 32'h1);

    // T3 write-one-to-clear, set beats clear
    wr(BASE + 32'h8, 32'h05);
    rd(BASE + 32'h8, d); chk("t3_w1c", d, 32'hA0);
    PortIn = 8'hA4;
    tick(3);
    rd(BASE + 32'h8, d); chk("t3_fall", d, 32'hA0);
    PortIn = 8'hA5;
    tick(2);
    wr(BASE + 32'h8, 32'h01);
    rd(BASE + 32'h8, d); chk("t3_set_wins", d, 32'hA1);
    wr(BASE + 32'h8, 32'hFF);
    rd(BASE + 32'h8, d); chk("t3_clear_all", d, 32'h0);
    chk("t3_pend_clr", {31'b0, EventPending}, 32'h0);

    // T4 input held high through reset release
    PortIn = 8'hFF;
    reset = 1'b1;
    tick();
    chk("t4_rst_portout", PortOut, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t4_quiet_%0d", i), {31'b0, EventPending}, 32'h0);
    end
    rd(BASE + 32'h8, d); chk("t4_ev_quiet", d, 32'h0);
    PortIn = 8'hF7;
    tick(3);
    PortIn = 8'hFF;
    tick(3);
    rd(BASE + 32'h8, d); chk("t4_bit3", d, 32'h08);

    // T5 timer load and wrap, misaligned stores
    wr(BASE + 32'hC, 32'hFFFF_FFFE);
    rd(BASE + 32'hC, d); chk("t5_loaded", d, 32'hFFFF_FFFE);
    tick();
    rd(BASE + 32'hC, d); chk("t5_max", d, 32'hFFFF_FFFF);
    tick();
    rd(BASE + 32'hC, d); chk("t5_wrap", d, 32'h0);
    Address = BASE + 32'hD; WriteData = 32'h5555_0000; MemWrite = 1'b1; #1;
    chk("t5_mis_hit", {31'b0, Hit}, 32'h0);
    tick();
    MemWrite = 1'b0;
    rd(BASE + 32'hC, d); chk("t5_mis_timer", d, 32'h1);
    wr(BASE + 32'h1, 32'h0BAD_0BAD);
    chk("t5_mis_portout", PortOut, 32'h0);
    wr(BASE, 32'hCAFE_0001);
    chk("t5_portout", PortOut, 32'hCAFE_0001);

    // T6 reset in the middle of a store, out-of-window decode
    Address = BASE; WriteData = 32'hCAFE_F00D; MemWrite = 1'b1;
    #2 reset = 1'b1;
    #1 chk("t6_async_portout", PortOut, 32'h0);
    chk("t6_async_pend", {31'b0, EventPending}, 32'h0);
    tick();
    chk("t6_held_portout", PortOut, 32'h0);
    MemWrite = 1'b0;
    rd(BASE + 32'hC, d); chk("t6_timer", d, 32'h0);
    rd(BASE + 32'h8, d); chk("t6_event", d, 32'h0);
    reset = 1'b0;
    Address = BASE + 32'h10; MemRead = 1'b1; #1;
    chk("t6_out_hit", {31'b0, Hit}, 32'h0);
    chk("t6_out_rdata", ReadData, 32'h0);
    Address = BASE - 32'h4; #1;
    chk("t6_below_hit", {31'b0, Hit}, 32'h0);
    chk("t6_below_rdata", ReadData, 32'h0);
    MemRead = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
